// File: rtl/rename_dest_alloc.sv
// rename_dest_alloc
//   Single-lane register rename stage sitting directly after the physical
//   register freelist. Each accepted instruction looks up its two sources
//   in the speculative RAT and, when it writes a non-zero GPR, pops the
//   freelist head as its new destination. The displaced mapping is passed
//   downstream so the ROB can free it at commit. A committed RAT, fed by
//   the commit port, restores the speculative RAT on a flush.
//
// Ports
//   Clk, Rest                    clock, async active-low reset
//   InValid/InReady              decode handshake
//   InHasDest, InRd, InRj, InRk  architectural operands
//   FlPreOut, FlEmpty, FlRable   freelist head peek, empty flag, pop strobe
//   OutValid/OutReady            dispatch handshake
//   OutHasDest, OutPrj, OutPrk,
//   OutPrd, OutOldPrd            renamed instruction fields
//   CmtValid, CmtRd, CmtPrd      retiring destination mapping
//   Flush                        pipeline redirect
module rename_dest_alloc #(
  parameter int AREGW = 5,
  parameter int PREGW = 7,
  parameter int NAREG = 32
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             InValid,
  output logic             InReady,
  input  logic             InHasDest,
  input  logic [AREGW-1:0] InRd,
  input  logic [AREGW-1:0] InRj,
  input  logic [AREGW-1:0] InRk,
  input  logic [PREGW-1:0] FlPreOut,
  input  logic             FlEmpty,
  output logic             FlRable,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             OutHasDest,
  output logic [PREGW-1:0] OutPrj,
  output logic [PREGW-1:0] OutPrk,
  output logic [PREGW-1:0] OutPrd,
  output logic [PREGW-1:0] OutOldPrd,
  input  logic             CmtValid,
  input  logic [AREGW-1:0] CmtRd,
  input  logic [PREGW-1:0] CmtPrd,
  input  logic             Flush
);

  logic [PREGW-1:0] r_spec_rat [NAREG];
  logic [PREGW-1:0] r_cmt_rat  [NAREG];

  logic             r_out_valid;
  logic             r_out_has_dest;
  logic [PREGW-1:0] r_out_prj;
  logic [PREGW-1:0] r_out_prk;
  logic [PREGW-1:0] r_out_prd;
  logic [PREGW-1:0] r_out_old_prd;

  logic             w_need_dest;
  logic             w_stall;
  logic             w_slot_free;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_cmt_we;
  logic [PREGW-1:0] w_prj;
  logic [PREGW-1:0] w_prk;
  logic [PREGW-1:0] w_old_prd;

  // Writes to x0 are not renamed: they neither consume a free register
  // nor disturb the mapping of entry 0.
  assign w_need_dest = InHasDest && (InRd != '0);
  assign w_stall     = w_need_dest && FlEmpty;
  assign w_slot_free = !r_out_valid || OutReady;
  assign w_in_ready  = w_slot_free && !w_stall && !Flush;
  assign w_accept    = InValid && w_in_ready;
  assign w_cmt_we    = CmtValid && (CmtRd != '0);

  // Reads see the table before this instruction's own write, so a source
  // equal to the destination gets the old mapping. The previous
  // instruction's write has already landed on its accept edge, so
  // back-to-back dependents need no bypass.
  assign w_prj     = (InRj == '0) ? '0 : r_spec_rat[InRj];
  assign w_prk     = (InRk == '0) ? '0 : r_spec_rat[InRk];
  assign w_old_prd = r_spec_rat[InRd];

  assign InReady    = w_in_ready;
  assign FlRable    = w_accept && w_need_dest;
  assign OutValid   = r_out_valid;
  assign OutHasDest = r_out_has_dest;
  assign OutPrj     = r_out_prj;
  assign OutPrk     = r_out_prk;
  assign OutPrd     = r_out_prd;
  assign OutOldPrd  = r_out_old_prd;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < NAREG; i++) r_cmt_rat[i] <= PREGW'(i);
    end else if (w_cmt_we) begin
      r_cmt_rat[CmtRd] <= CmtPrd;
    end
  end

  // On flush the committed table is copied back with a same-cycle commit
  // merged in, so a retirement coinciding with the flush is not lost.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < NAREG; i++) r_spec_rat[i] <= PREGW'(i);
    end else if (Flush) begin
      for (int i = 1; i < NAREG; i++) begin
        r_spec_rat[i] <= (w_cmt_we && (CmtRd == AREGW'(i))) ? CmtPrd : r_cmt_rat[i];
      end
    end else if (w_accept && w_need_dest) begin
      r_spec_rat[InRd] <= FlPreOut;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_out_valid <= 1'b0;
    end else if (Flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (OutReady) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_out_has_dest <= 1'b0;
      r_out_prj      <= '0;
      r_out_prk      <= '0;
      r_out_prd      <= '0;
      r_out_old_prd  <= '0;
    end else if (w_accept) begin
      r_out_has_dest <= w_need_dest;
      r_out_prj      <= w_prj;
      r_out_prk      <= w_prk;
      r_out_prd      <= w_need_dest ? FlPreOut : '0;
      r_out_old_prd  <= w_need_dest ? w_old_prd : '0;
    end
  end

endmodule

// File: tb/tb_rename_dest_alloc.sv
module tb_rename_dest_alloc;

  logic       Clk = 1'b0;
  logic       Rest;
  logic       InValid;
  logic       InReady;
  logic       InHasDest;
  logic [4:0] InRd, InRj, InRk;
  logic [6:0] FlPreOut;
  logic       FlEmpty;
  logic       FlRable;
  logic       OutValid;
  logic       OutReady;
  logic       OutHasDest;
  logic [6:0] OutPrj, OutPrk, OutPrd, OutOldPrd;
  logic       CmtValid;
  logic [4:0] CmtRd;
  logic [6:0] CmtPrd;
  logic       Flush;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  rename_dest_alloc dut (
    .Clk(Clk), .Rest(Rest),
    .InValid(InValid), .InReady(InReady), .InHasDest(InHasDest),
    .InRd(InRd), .InRj(InRj), .InRk(InRk),
    .FlPreOut(FlPreOut), .FlEmpty(FlEmpty), .FlRable(FlRable),
    .OutValid(OutValid), .OutReady(OutReady), .OutHasDest(OutHasDest),
    .OutPrj(OutPrj), .OutPrk(OutPrk), .OutPrd(OutPrd), .OutOldPrd(OutOldPrd),
    .CmtValid(CmtValid), .CmtRd(CmtRd), .CmtPrd(CmtPrd),
    .Flush(Flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; registered outputs are checked on
  // the following falling edge, combinational outputs 1ns after driving.
  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic offer(input logic hd, input int rd, input int rj, input int rk, input int fl);
    InValid   = 1'b1;
    InHasDest = hd;
    InRd      = 5'(rd);
    InRj      = 5'(rj);
    InRk      = 5'(rk);
    FlPreOut  = 7'(fl);
    #1;
  endtask

  initial begin
    Rest = 1'b0; InValid = 0; InHasDest = 0; InRd = 0; InRj = 0; InRk = 0;
    FlPreOut = 0; FlEmpty = 0; OutReady = 1; CmtValid = 0; CmtRd = 0;
    CmtPrd = 0; Flush = 0;
    #12;
    chk("rst_valid", OutValid, 0);
    chk("rst_prd", OutPrd, 0);
    chk("rst_oldprd", OutOldPrd, 0);
    chk("rst_prj", OutPrj, 0);
    @(negedge Clk);
    Rest = 1'b1;
    @(negedge Clk);

    // first rename: rd=5 -> 33
    offer(1, 5, 5, 0, 33);
    chk("t1_ready", InReady, 1);
    chk("t1_pop", FlRable, 1);
    cyc();
    chk("t1_valid", OutValid, 1);
    chk("t1_hasdest", OutHasDest, 1);
    chk("t1_prj", OutPrj, 5);
    chk("t1_prk", OutPrk, 0);
    chk("t1_prd", OutPrd, 33);
    chk("t1_oldprd", OutOldPrd, 5);

    // dependent back-to-back: rj=5 sees 33
    offer(1, 6, 5, 0, 37);
    chk("t2_pop", FlRable, 1);
    cyc();
    chk("t2_valid", OutValid, 1);
    chk("t2_prj", OutPrj, 33);
    chk("t2_prd", OutPrd, 37);
    chk("t2_oldprd", OutOldPrd, 6);

    // freelist empty stalls a real destination
    FlEmpty = 1'b1;
    offer(1, 9, 1, 2, 40);
    chk("t3_stall_ready", InReady, 0);
    chk("t3_stall_pop", FlRable, 0);
    cyc();
    chk("t3_drained", OutValid, 0);
    // rd=0 still goes through
    offer(1, 0, 6, 5, 40);
    chk("t3_x0_ready", InReady, 1);
    chk("t3_x0_pop", FlRable, 0);
    cyc();
    chk("t3_x0_valid", OutValid, 1);
    chk("t3_x0_hasdest", OutHasDest, 0);
    chk("t3_x0_prd", OutPrd, 0);
    chk("t3_x0_oldprd", OutOldPrd, 0);
    chk("t3_x0_prj", OutPrj, 37);
    chk("t3_x0_prk", OutPrk, 33);
    // no destination at all
    offer(0, 3, 0, 6, 40);
    chk("t3_nd_ready", InReady, 1);
    chk("t3_nd_pop", FlRable, 0);
    cyc();
    chk("t3_nd_hasdest", OutHasDest, 0);
    chk("t3_nd_prk", OutPrk, 37);
    chk("t3_nd_prj", OutPrj, 0);

    // backpressure for 3 cycles
    FlEmpty  = 1'b0;
    OutReady = 1'b0;
    offer(1, 10, 6, 0, 50);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_ready", InReady, 0);
      chk("t4_hold_pop", FlRable, 0);
      cyc();
      chk("t4_hold_valid", OutValid, 1);
      chk("t4_hold_prk", OutPrk, 37);
    end
    OutReady = 1'b1;
    #1;
    chk("t4_rel_ready", InReady, 1);
    chk("t4_rel_pop", FlRable, 1);
    cyc();
    chk("t4_rel_prd", OutPrd, 50);
    chk("t4_rel_oldprd", OutOldPrd, 10);
    chk("t4_rel_prj", OutPrj, 37);

    // rename 7 -> 41, commit it, rename 7 -> 45, flush
    offer(1, 7, 0, 0, 41);
    cyc();
    chk("t5_a_prd", OutPrd, 41);
    chk("t5_a_oldprd", OutOldPrd, 7);
    InValid = 0; CmtValid = 1; CmtRd = 7; CmtPrd = 41;
    cyc();
    CmtValid = 0;
    offer(1, 7, 0, 0, 45);
    cyc();
    chk("t5_b_prd", OutPrd, 45);
    chk("t5_b_oldprd", OutOldPrd, 41);
    InValid = 0; OutReady = 0; Flush = 1;
    cyc();
    Flush = 0; OutReady = 1;
    chk("t5_flush_valid", OutValid, 0);
    offer(0, 0, 7, 10, 0);
    cyc();
    chk("t5_after_prj", OutPrj, 41);
    chk("t5_after_prk", OutPrk, 10);

    // flush with a same-cycle commit; offered instruction is refused
    Flush = 1; CmtValid = 1; CmtRd = 8; CmtPrd = 49;
    offer(1, 8, 0, 0, 60);
    chk("t6_flush_ready", InReady, 0);
    chk("t6_flush_pop", FlRable, 0);
    cyc();
    Flush = 0; CmtValid = 0;
    chk("t6_flush_valid", OutValid, 0);
    offer(0, 0, 8, 7, 0);
    cyc();
    chk("t6_merge_prj", OutPrj, 49);
    chk("t6_merge_prk", OutPrk, 41);

    // asynchronous reset mid-operation
    offer(1, 12, 8, 0, 70);
    cyc();
    chk("t7_pre_prd", OutPrd, 70);
    #2 Rest = 1'b0;
    #1;
    chk("t7_rst_valid", OutValid, 0);
    chk("t7_rst_prd", OutPrd, 0);
    @(negedge Clk);
    Rest = 1'b1;
    offer(0, 0, 8, 7, 0);
    cyc();
    chk("t7_ident_prj", OutPrj, 8);
    chk("t7_ident_prk", OutPrk, 7);
    InValid = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rename_dest_alloc.md
Name: rename_dest_alloc

Overview:
- Single-lane rename stage directly downstream of the physical-register freelist bank.
- Reads source mappings from a speculative register alias table (RAT) and pops one free physical register per instruction that writes a destination.
- Records the previous mapping so the ROB can release it at commit.
- Keeps a committed RAT, updated from the commit port, which restores the speculative RAT on flush.

Parameters:
AREGW, 5, architectural register index width
PREGW, 7, physical register index width (matches freelist entry width)
NAREG, 32, number of architectural registers

Ports:
Clk  input  1  clock; all state updates on rising edge
Rest  input  1  asynchronous active-low reset
InValid  input  1  decode offers an instruction
InReady  output  1  stage accepts this cycle
InHasDest  input  1  instruction writes a GPR
InRd  input  AREGW  architectural destination
InRj  input  AREGW  architectural source 1
InRk  input  AREGW  architectural source 2
FlPreOut  input  PREGW  freelist head entry, combinational peek
FlEmpty  input  1  freelist empty
FlRable  output  1  pop freelist head this cycle
OutValid  output  1  renamed instruction valid
OutReady  input  1  dispatch accepts renamed instruction
OutHasDest  output  1  destination was renamed
OutPrj  output  PREGW  physical source 1
OutPrk  output  PREGW  physical source 2
OutPrd  output  PREGW  newly allocated physical destination
OutOldPrd  output  PREGW  prior mapping of InRd, for release at commit
CmtValid  input  1  an instruction with a renamed destination retires
CmtRd  input  AREGW  retiring architectural destination
CmtPrd  input  PREGW  retiring physical destination
Flush  input  1  pipeline flush/redirect

Behaviour:
- Reset (Rest low, asynchronous):
  - Both RATs: entry i = i, for i = 0..31.
  - OutValid = 0; OutHasDest, OutPrj, OutPrk, OutPrd and OutOldPrd = 0.
- Definitions:
  - NeedDest = InHasDest && (InRd != 0).
  - Stall = NeedDest && FlEmpty.
  - Slot free = !OutValid || OutReady.
- InReady = slot free && !Stall && !Flush. This is combinational.
- Accept = InValid && InReady.
- FlRable = Accept && NeedDest. It is combinational, so the pop happens the same cycle FlPreOut is consumed. FlRable is never asserted when FlEmpty = 1 or Flush = 1.
- Source lookup:
  - Combinational read of the speculative RAT, taken before this instruction's own write.
  - Rj == Rd therefore returns the old mapping.
  - Index 0 always returns 0.
- On Accept, the output register loads on the next edge, giving one-cycle latency:
  - OutPrj = RAT[InRj]; OutPrk = RAT[InRk].
  - OutHasDest = NeedDest.
  - OutPrd = NeedDest ? FlPreOut : 0.
  - OutOldPrd = NeedDest ? RAT[InRd] : 0.
  - If NeedDest, speculative RAT[InRd] <= FlPreOut on the same edge.
- The output holds while OutValid && !OutReady. Output fields change only on Accept.
- OutValid next value:
  - 1 on Accept.
  - Else 0 if OutReady.
  - Else holds.
- Back-to-back dependent instructions: the RAT write lands on the accept edge, so the next instruction reads the new mapping. No bypass is needed.
- Commit: if CmtValid && CmtRd != 0, committed RAT[CmtRd] <= CmtPrd. Commit is independent of Flush and Accept.
- Flush (synchronous, highest priority over Accept):
  - Speculative RAT <= committed RAT, with a same-cycle commit write merged in (the restored entry CmtRd = CmtPrd).
  - OutValid <= 0.
  - No freelist pop occurs.
- Entry 0 of both RATs is never written and stays 0.
- Reset mid-operation discards the in-flight output and restores both RATs to identity immediately.

Test Plan:
- Reset, then offer add rd=5, rj=5, rk=0 with FlPreOut=33 and FlEmpty=0 → FlRable pulses 1 cycle; next cycle OutValid=1, OutPrj=5, OutPrk=0, OutPrd=33, OutOldPrd=5.
- Follow immediately with rd=6, rj=5 and FlPreOut=37 → OutPrj=33, OutPrd=37, OutOldPrd=6. No bubble when OutReady=1.
- FlEmpty=1 with NeedDest → InReady=0 and FlRable=0. An instruction with rd=0 or InHasDest=0 is still accepted, giving OutHasDest=0 and OutPrd=0.
- OutReady=0 for 3 cycles with the output valid → outputs stable, InReady=0, no pop. Releasing OutReady accepts the next instruction the same cycle.
- Rename rd=7→41, commit (7, 41), rename rd=7→45, then Flush → OutValid=0 next cycle. A following rj=7 lookup gives OutPrj=41.
- Flush and CmtValid(8, 49) in the same cycle → after the flush, rj=8 gives OutPrj=49. An InValid asserted during the flush cycle sees InReady=0 and FlRable=0.
